// File: rtl/apb_boot_pkg.sv
// Shared types and default timing constants for the APB boot sequencer.
package apb_boot_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StWrite,
    StGap,
    StCoreRst,
    StRun,
    StDone
  } boot_state_t;

  localparam int unsigned BOOT_HOLD_CYCLES = 4;
  localparam int unsigned BOOT_RST_CYCLES  = 2;
  localparam int unsigned BOOT_RUN_TIMEOUT = 5000;

  function automatic int unsigned boot_max3(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/boot_down_counter.sv
// Loadable down-counter that saturates at zero and flags it.
module boot_down_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/apb_boot_master.sv
// Boot sequencer: copies ROM words into the core over its load port, then resets and runs
// the core under a watchdog.
module apb_boot_master
  import apb_boot_pkg::*;
#(
  parameter int unsigned DATA_LENGTH    = 32,
  parameter int unsigned ADDRESS_LENGTH = 12,
  parameter int unsigned HOLD_CYCLES    = BOOT_HOLD_CYCLES,
  parameter int unsigned RST_CYCLES     = BOOT_RST_CYCLES,
  parameter int unsigned RUN_TIMEOUT    = BOOT_RUN_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDRESS_LENGTH:0]   word_count,
  output logic                      rom_en,
  output logic [ADDRESS_LENGTH-1:0] rom_addr,
  input  logic [DATA_LENGTH-1:0]    rom_data,
  output logic [31:0]               addr_in,
  output logic [DATA_LENGTH-1:0]    data_in,
  output logic                      pselect,
  output logic                      pwrite,
  output logic                      pready,
  output logic                      instruction_load_start,
  output logic                      core_select,
  output logic                      core_rst_n,
  input  logic                      run_complete,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout
);

  localparam int unsigned CNT_W = $clog2(boot_max3(HOLD_CYCLES, RST_CYCLES, RUN_TIMEOUT) + 1);
  // Counter is preloaded with N-1 so the zero flag marks the last cycle of each phase.
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LD  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LD  = CNT_W'(RUN_TIMEOUT - 1);

  boot_state_t               r_state;
  logic [ADDRESS_LENGTH:0]   r_count;
  logic [ADDRESS_LENGTH:0]   r_index;
  logic                      r_rom_en;
  logic [ADDRESS_LENGTH-1:0] r_rom_addr;
  logic [31:0]               r_addr_in;
  logic [DATA_LENGTH-1:0]    r_data_in;
  logic                      r_strobe;
  logic                      r_ils;
  logic                      r_core_select;
  logic                      r_core_rst_n;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_timeout;

  logic [ADDRESS_LENGTH:0]   w_index_nxt;
  logic                      w_last;
  logic                      w_cnt_load;
  logic [CNT_W-1:0]          w_cnt_value;
  logic                      w_cnt_dec;
  logic                      w_cnt_zero;

  assign w_index_nxt = r_index + (ADDRESS_LENGTH + 1)'(1);
  assign w_last      = (w_index_nxt == r_count);

  always_comb begin
    w_cnt_load  = 1'b0;
    w_cnt_value = '0;
    w_cnt_dec   = 1'b0;
    unique case (r_state)
      StIdle, StDone: begin
        if (start && (word_count == '0)) begin
          w_cnt_load  = 1'b1;
          w_cnt_value = RST_LD;
        end
      end
      StWait: begin
        w_cnt_load  = 1'b1;
        w_cnt_value = HOLD_LD;
      end
      StWrite, StRun: w_cnt_dec = 1'b1;
      StGap: begin
        if (w_last) begin
          w_cnt_load  = 1'b1;
          w_cnt_value = RST_LD;
        end
      end
      StCoreRst: begin
        if (w_cnt_zero) begin
          w_cnt_load  = 1'b1;
          w_cnt_value = RUN_LD;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      default: ;
    endcase
  end

  boot_down_counter #(
    .WIDTH (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_cnt_load),
    .i_value (w_cnt_value),
    .i_dec   (w_cnt_dec),
    .o_zero  (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_count       <= '0;
      r_index       <= '0;
      r_rom_en      <= 1'b0;
      r_rom_addr    <= '0;
      r_addr_in     <= '0;
      r_data_in     <= '0;
      r_strobe      <= 1'b0;
      r_ils         <= 1'b0;
      r_core_select <= 1'b0;
      r_core_rst_n  <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (start) begin
            r_count      <= word_count;
            r_index      <= '0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_busy       <= 1'b1;
            r_core_rst_n <= 1'b0;
            if (word_count == '0) begin
              r_state       <= StCoreRst;
              r_core_select <= 1'b1;
              r_ils         <= 1'b0;
            end else begin
              r_state       <= StFetch;
              r_core_select <= 1'b0;
              r_ils         <= 1'b1;
              r_rom_en      <= 1'b1;
              r_rom_addr    <= '0;
            end
          end
        end
        StFetch: begin
          r_rom_en <= 1'b0;
          r_state  <= StWait;
        end
        StWait: begin
          r_data_in <= rom_data;
          r_addr_in <= 32'(r_index[ADDRESS_LENGTH-1:0]);
          r_strobe  <= 1'b1;
          r_state   <= StWrite;
        end
        StWrite: begin
          if (w_cnt_zero) begin
            r_strobe <= 1'b0;
            r_state  <= StGap;
          end
        end
        StGap: begin
          r_index <= w_index_nxt;
          if (w_last) begin
            r_state       <= StCoreRst;
            r_core_select <= 1'b1;
            r_ils         <= 1'b0;
          end else begin
            r_state    <= StFetch;
            r_rom_en   <= 1'b1;
            r_rom_addr <= w_index_nxt[ADDRESS_LENGTH-1:0];
          end
        end
        StCoreRst: begin
          if (w_cnt_zero) begin
            r_state      <= StRun;
            r_core_rst_n <= 1'b1;
          end
        end
        StRun: begin
          // Completion takes priority over a watchdog expiry in the same cycle.
          if (run_complete) begin
            r_state <= StDone;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else if (w_cnt_zero) begin
            r_state   <= StDone;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign rom_en                 = r_rom_en;
  assign rom_addr               = r_rom_addr;
  assign addr_in                = r_addr_in;
  assign data_in                = r_data_in;
  assign pselect                = r_strobe;
  assign pwrite                 = r_strobe;
  assign pready                 = r_strobe;
  assign instruction_load_start = r_ils;
  assign core_select            = r_core_select;
  assign core_rst_n             = r_core_rst_n;
  assign busy                   = r_busy;
  assign done                   = r_done;
  assign timeout                = r_timeout;

endmodule

// File: tb/tb_apb_boot_master.sv
// Directed bench for apb_boot_master: per-cycle vector table for a 3-word load plus
// hand-written completion, watchdog, empty-load, reset and restart sequences.
module tb_apb_boot_master;

  localparam logic [31:0] W0 = 32'h0050_0093;
  localparam logic [31:0] W1 = 32'h0010_0113;
  localparam logic [31:0] W2 = 32'h0020_81B3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [12:0] word_count = '0;
  logic        rom_en;
  logic [11:0] rom_addr;
  logic [31:0] rom_data = '0;
  logic [31:0] addr_in;
  logic [31:0] data_in;
  logic        pselect, pwrite, pready;
  logic        instruction_load_start, core_select, core_rst_n;
  logic        run_complete = 1'b0;
  logic        busy, done, timeout;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    int          cyc;
    logic        rom_en;
    logic [11:0] raddr;
    logic        strobe;
    logic        ad;      // compare addr_in/data_in in this cycle
    logic [31:0] addr;
    logic [31:0] data;
    logic        ils;
    logic        csel;
    logic        crst;
  } vec_t;

  vec_t tbl [17];

  apb_boot_master #(
    .DATA_LENGTH    (32),
    .ADDRESS_LENGTH (12),
    .HOLD_CYCLES    (4),
    .RST_CYCLES     (2),
    .RUN_TIMEOUT    (20)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .start                  (start),
    .word_count             (word_count),
    .rom_en                 (rom_en),
    .rom_addr               (rom_addr),
    .rom_data               (rom_data),
    .addr_in                (addr_in),
    .data_in                (data_in),
    .pselect                (pselect),
    .pwrite                 (pwrite),
    .pready                 (pready),
    .instruction_load_start (instruction_load_start),
    .core_select            (core_select),
    .core_rst_n             (core_rst_n),
    .run_complete           (run_complete),
    .busy                   (busy),
    .done                   (done),
    .timeout                (timeout)
  );

  always #5 clk = ~clk;

  // 1-cycle-latency ROM
  always @(posedge clk) begin
    if (rom_en) begin
      case (rom_addr)
        12'd0:   rom_data <= W0;
        12'd1:   rom_data <= W1;
        12'd2:   rom_data <= W2;
        default: rom_data <= 32'hDEAD_BEEF;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [85:0] obs();
    return {rom_en, rom_addr, pselect, pwrite, pready, addr_in, data_in,
            instruction_load_start, core_select, core_rst_n, busy, done, timeout};
  endfunction

  task automatic check(input string name, input logic [85:0] act, input logic [85:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Status bits: {rom_en, pselect, ils, core_select, core_rst_n, busy, done, timeout}
  function automatic logic [7:0] status();
    return {rom_en, pselect, instruction_load_start, core_select, core_rst_n, busy, done,
            timeout};
  endfunction

  // Starts a 3-word load and walks it to the first RUN cycle (c=24).
  task automatic load_run(input string tag, input bit inject_start);
    int          idx;
    int          beats;
    logic [85:0] act;
    logic [85:0] exp;
    idx   = 0;
    beats = 0;
    word_count = 13'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      beats += int'(pselect);
      if (inject_start && c == 4) begin
        start      = 1'b1;
        word_count = 13'd0;
      end else if (inject_start && c == 5) begin
        start      = 1'b0;
        word_count = 13'd3;
      end
      if (idx < 17 && tbl[idx].cyc == c) begin
        act = obs();
        exp = {tbl[idx].rom_en, tbl[idx].raddr, {3{tbl[idx].strobe}}, tbl[idx].addr,
               tbl[idx].data, tbl[idx].ils, tbl[idx].csel, tbl[idx].crst, 3'b100};
        if (!tbl[idx].ad) begin
          act[69:6] = '0;
          exp[69:6] = '0;
        end
        check($sformatf("%s_c%0d", tag, c), act, exp);
        idx++;
      end
      if (c < 24) step();
    end
    check({tag, "_beats"}, 86'(beats), 86'(12));
  endtask

  // From the first RUN cycle, pulse run_complete in the 10th RUN cycle.
  task automatic complete_run(input string tag);
    for (int i = 0; i < 9; i++) step();
    check({tag, "_run10"}, 86'(status()), 86'(8'b0001_1100));
    run_complete = 1'b1;
    step();
    run_complete = 1'b0;
    check({tag, "_done"}, 86'(status()), 86'(8'b0001_1010));
  endtask

  // Empty load straight into RUN; the watchdog expires after 20 RUN cycles.
  task automatic empty_run(input string tag, input bit rc_at_expiry);
    logic act;
    act = 1'b0;
    word_count = 13'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    run_complete = 1'b1;  // outside RUN, must be ignored
    check({tag, "_c1"}, 86'(status()), 86'(8'b0001_0100));
    for (int c = 1; c <= 22; c++) begin
      act |= rom_en | pselect | pwrite | pready | instruction_load_start;
      if (c == 3) begin
        run_complete = 1'b0;
        check({tag, "_runentry"}, 86'(status()), 86'(8'b0001_1100));
      end
      if (c == 22) begin
        check({tag, "_c22"}, 86'(status()), 86'(8'b0001_1100));
        if (rc_at_expiry) run_complete = 1'b1;
      end
      step();
    end
    run_complete = 1'b0;
    check({tag, "_end"}, 86'(status()), {78'd0, 7'b0001_101, !rc_at_expiry});
    check({tag, "_noload"}, 86'(act), 86'(0));
  endtask

  initial begin
    tbl[0]  = '{1,  1'b1, 12'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{2,  1'b0, 12'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{3,  1'b0, 12'd0, 1'b1, 1'b1, 32'd0, W0,    1'b1, 1'b0, 1'b0};
    tbl[3]  = '{6,  1'b0, 12'd0, 1'b1, 1'b1, 32'd0, W0,    1'b1, 1'b0, 1'b0};
    tbl[4]  = '{7,  1'b0, 12'd0, 1'b0, 1'b1, 32'd0, W0,    1'b1, 1'b0, 1'b0};
    tbl[5]  = '{8,  1'b1, 12'd1, 1'b0, 1'b1, 32'd0, W0,    1'b1, 1'b0, 1'b0};
    tbl[6]  = '{9,  1'b0, 12'd1, 1'b0, 1'b1, 32'd0, W0,    1'b1, 1'b0, 1'b0};
    tbl[7]  = '{10, 1'b0, 12'd1, 1'b1, 1'b1, 32'd1, W1,    1'b1, 1'b0, 1'b0};
    tbl[8]  = '{13, 1'b0, 12'd1, 1'b1, 1'b1, 32'd1, W1,    1'b1, 1'b0, 1'b0};
    tbl[9]  = '{14, 1'b0, 12'd1, 1'b0, 1'b1, 32'd1, W1,    1'b1, 1'b0, 1'b0};
    tbl[10] = '{15, 1'b1, 12'd2, 1'b0, 1'b1, 32'd1, W1,    1'b1, 1'b0, 1'b0};
    tbl[11] = '{17, 1'b0, 12'd2, 1'b1, 1'b1, 32'd2, W2,    1'b1, 1'b0, 1'b0};
    tbl[12] = '{20, 1'b0, 12'd2, 1'b1, 1'b1, 32'd2, W2,    1'b1, 1'b0, 1'b0};
    tbl[13] = '{21, 1'b0, 12'd2, 1'b0, 1'b1, 32'd2, W2,    1'b1, 1'b0, 1'b0};
    tbl[14] = '{22, 1'b0, 12'd2, 1'b0, 1'b1, 32'd2, W2,    1'b0, 1'b1, 1'b0};
    tbl[15] = '{23, 1'b0, 12'd2, 1'b0, 1'b1, 32'd2, W2,    1'b0, 1'b1, 1'b0};
    tbl[16] = '{24, 1'b0, 12'd2, 1'b0, 1'b1, 32'd2, W2,    1'b0, 1'b1, 1'b1};

    step();
    check("reset_outputs", obs(), 86'd0);
    step();
    rst_n = 1'b1;
    step();
    check("idle_outputs", obs(), 86'd0);

    load_run("load1", 1'b0);
    complete_run("load1");

    empty_run("wdog", 1'b0);

    // Restart from DONE with timeout set; a start mid-WRITE must be ignored.
    load_run("restart", 1'b1);
    complete_run("restart");

    empty_run("wdog_race", 1'b1);

    // Asynchronous reset during the second WRITE beat.
    word_count = 13'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 11; c++) step();
    check("midload_beat2", 86'({pselect, addr_in}), 86'({1'b1, 32'd1}));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", obs(), 86'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("post_reset_idle", obs(), 86'd0);

    load_run("reload", 1'b0);
    complete_run("reload");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
